// File: rtl/iccm_port_arbiter_if.sv
// rtl/iccm_port_arbiter_if.sv - requester and SRAM-side bus bundle for the ICCM port arbiter
//
// Signal suffixes are written from the arbiter's point of view (_i into it, _o out of it).
//   f_*  : core fetch path (read-only)
//   l_*  : program loader (read/write)
//   m_*  : single SRAM port towards instr_mem_top
// Modports:
//   slave  : the arbiter
//   master : the surrounding requesters and SRAM
interface iccm_port_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          f_req_i;
    logic [AW-1:0] f_addr_i;
    logic          f_gnt_o;
    logic          f_rvalid_o;
    logic [DW-1:0] f_rdata_o;

    logic          l_req_i;
    logic          l_we_i;
    logic [AW-1:0] l_addr_i;
    logic [DW-1:0] l_wdata_i;
    logic          l_gnt_o;
    logic          l_rvalid_o;
    logic [DW-1:0] l_rdata_o;

    logic          m_req_o;
    logic          m_we_o;
    logic [AW-1:0] m_addr_o;
    logic [DW-1:0] m_wdata_o;
    logic [DW-1:0] m_wmask_o;
    logic [DW-1:0] m_rdata_i;
    logic          m_rvalid_i;

    modport slave (
        input  f_req_i, f_addr_i,
        input  l_req_i, l_we_i, l_addr_i, l_wdata_i,
        input  m_rdata_i, m_rvalid_i,
        output f_gnt_o, f_rvalid_o, f_rdata_o,
        output l_gnt_o, l_rvalid_o, l_rdata_o,
        output m_req_o, m_we_o, m_addr_o, m_wdata_o, m_wmask_o
    );

    modport master (
        output f_req_i, f_addr_i,
        output l_req_i, l_we_i, l_addr_i, l_wdata_i,
        output m_rdata_i, m_rvalid_i,
        input  f_gnt_o, f_rvalid_o, f_rdata_o,
        input  l_gnt_o, l_rvalid_o, l_rdata_o,
        input  m_req_o, m_we_o, m_addr_o, m_wdata_o, m_wmask_o
    );
endinterface

// File: rtl/iccm_port_arbiter.sv
// rtl/iccm_port_arbiter.sv - shares the single-port ICCM SRAM between core fetch and program loader
//
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   boot_hold_i      : high while the core is held in reset for programming
//   bus (slave)      : fetch/loader request+return and SRAM port bundle
//   phase_o          : LOAD=0, DRAIN=1, RUN=2
//   conflict_cnt_o   : RUN cycles with both requesters asking   (ICCM_ARB_STATS_EN only)
//   starve_cnt_o     : forced loader grants after MaxWait cycles (ICCM_ARB_STATS_EN only)
// Optional feature macro: ICCM_ARB_STATS_EN
module iccm_port_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int MaxWait = 4,
    parameter int StatW   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  boot_hold_i,
    iccm_port_arbiter_if.slave    bus,
    output logic [1:0]            phase_o
`ifdef ICCM_ARB_STATS_EN
    ,
    output logic [StatW-1:0]      conflict_cnt_o,
    output logic [StatW-1:0]      starve_cnt_o
`endif
);

    if (MaxWait < 1 || StatW < 1 || AW < 1 || DW < 1) begin : g_bad_param
        $error("iccm_port_arbiter: MaxWait, StatW, AW and DW must all be >= 1");
    end

    localparam int WW = $clog2(MaxWait + 1);
    localparam logic [WW-1:0] WaitMax = WW'(MaxWait);

    typedef enum logic [1:0] {
        PH_LOAD  = 2'd0,
        PH_DRAIN = 2'd1,
        PH_RUN   = 2'd2
    } phase_e;

    phase_e        phase_q, phase_d;
    logic [WW-1:0] wait_q, wait_d;
    // Owner of the access currently in the SRAM pipeline (at most one).
    logic          own_valid_q, own_valid_d;
    logic          own_ldr_q, own_ldr_d;
    logic          own_we_q, own_we_d;

    logic          f_gnt, l_gnt, forced;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q     <= PH_LOAD;
            wait_q      <= '0;
            own_valid_q <= 1'b0;
            own_ldr_q   <= 1'b0;
            own_we_q    <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            wait_q      <= wait_d;
            own_valid_q <= own_valid_d;
            own_ldr_q   <= own_ldr_d;
            own_we_q    <= own_we_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        f_gnt   = 1'b0;
        l_gnt   = 1'b0;
        forced  = 1'b0;
        unique case (phase_q)
            PH_LOAD: begin
                l_gnt = bus.l_req_i;
                if (!boot_hold_i) phase_d = PH_DRAIN;
            end
            PH_DRAIN: begin
                // No grants here, so the owner register is empty one cycle after entry.
                if (boot_hold_i)       phase_d = PH_LOAD;
                else if (!own_valid_q) phase_d = PH_RUN;
            end
            PH_RUN: begin
                forced = bus.l_req_i && (wait_q == WaitMax);
                l_gnt  = bus.l_req_i && (forced || !bus.f_req_i);
                f_gnt  = bus.f_req_i && !l_gnt;
                if (boot_hold_i) phase_d = PH_LOAD;
            end
            default: phase_d = PH_LOAD;
        endcase
    end

    // Loader starvation counter: only runs while RUN continues and the loader is refused.
    always_comb begin
        wait_d = '0;
        if (phase_q == PH_RUN && phase_d == PH_RUN && bus.l_req_i && !l_gnt) begin
            wait_d = (wait_q == WaitMax) ? wait_q : wait_q + 1'b1;
        end
    end

    always_comb begin
        own_valid_d = f_gnt || l_gnt;
        own_ldr_d   = l_gnt;
        own_we_d    = l_gnt && bus.l_we_i;
    end

    always_comb begin
        bus.f_gnt_o   = f_gnt;
        bus.l_gnt_o   = l_gnt;
        bus.m_req_o   = f_gnt || l_gnt;
        bus.m_we_o    = l_gnt && bus.l_we_i;
        bus.m_addr_o  = '0;
        bus.m_wdata_o = '0;
        if (l_gnt) begin
            bus.m_addr_o  = bus.l_addr_i;
            bus.m_wdata_o = bus.l_wdata_i;
        end else if (f_gnt) begin
            bus.m_addr_o  = bus.f_addr_i;
        end
        bus.m_wmask_o = (l_gnt && bus.l_we_i) ? '1 : '0;

        bus.f_rvalid_o = own_valid_q && !own_ldr_q && bus.m_rvalid_i;
        // Writes are acknowledged by the arbiter itself; the SRAM returns nothing for them.
        bus.l_rvalid_o = own_valid_q && own_ldr_q && (own_we_q || bus.m_rvalid_i);
        bus.f_rdata_o  = bus.f_rvalid_o ? bus.m_rdata_i : '0;
        bus.l_rdata_o  = bus.l_rvalid_o ? bus.m_rdata_i : '0;
    end

    assign phase_o = phase_q;

`ifdef ICCM_ARB_STATS_EN
    logic [StatW-1:0] conflict_q, conflict_d;
    logic [StatW-1:0] starve_q, starve_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_q <= '0;
            starve_q   <= '0;
        end else begin
            conflict_q <= conflict_d;
            starve_q   <= starve_d;
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        starve_d   = starve_q;
        if (phase_q == PH_RUN && bus.f_req_i && bus.l_req_i && conflict_q != '1) begin
            conflict_d = conflict_q + 1'b1;
        end
        if (forced && starve_q != '1) begin
            starve_d = starve_q + 1'b1;
        end
    end

    assign conflict_cnt_o = conflict_q;
    assign starve_cnt_o   = starve_q;
`endif

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// tb/tb_iccm_port_arbiter.sv - randomized self-checking bench for iccm_port_arbiter
module tb_iccm_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MaxWait = 4;
    localparam int StatW = 16;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic boot_hold = 1'b1;
    logic [1:0] phase;
`ifdef ICCM_ARB_STATS_EN
    logic [StatW-1:0] conflict_cnt, starve_cnt;
`endif

    always #5 clk = ~clk;

    iccm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    iccm_port_arbiter #(.AW(AW), .DW(DW), .MaxWait(MaxWait), .StatW(StatW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .boot_hold_i   (boot_hold),
        .bus           (bus),
        .phase_o       (phase)
`ifdef ICCM_ARB_STATS_EN
        ,
        .conflict_cnt_o(conflict_cnt),
        .starve_cnt_o  (starve_cnt)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM: fixed one-cycle read latency, masked writes, garbage data when not returning.
    logic          sram_rvalid = 1'b0;
    logic [DW-1:0] sram_rdata = '0;
    logic [DW-1:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        sram_rvalid <= bus.m_req_o && !bus.m_we_o;
        sram_rdata  <= (bus.m_req_o && !bus.m_we_o) ? sram[bus.m_addr_o] : DW'($urandom);
        if (bus.m_req_o && bus.m_we_o)
            sram[bus.m_addr_o] <= (sram[bus.m_addr_o] & ~bus.m_wmask_o) | (bus.m_wdata_o & bus.m_wmask_o);
    end
    assign bus.m_rvalid_i = sram_rvalid;
    assign bus.m_rdata_i  = sram_rdata;

    // Reference model: phase number, loader wait count, and the one access expected to return.
    int m_phase = 0, m_wait = 0, m_conf = 0, m_starve = 0;
    bit p_valid = 0, p_ldr = 0, p_we = 0;
    int n_phase = 0, n_wait = 0, n_conf = 0, n_starve = 0;
    bit n_valid = 0, n_ldr = 0, n_we = 0;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_phase <= 0; m_wait <= 0; m_conf <= 0; m_starve <= 0;
            p_valid <= 0; p_ldr <= 0; p_we <= 0;
        end else begin
            m_phase <= n_phase; m_wait <= n_wait; m_conf <= n_conf; m_starve <= n_starve;
            p_valid <= n_valid; p_ldr <= n_ldr; p_we <= n_we;
        end
    end

    always @(negedge clk) begin
        bit fr, lr, forced, eg_f, eg_l, e_we, e_frv, e_lrv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        fr = bus.f_req_i;
        lr = bus.l_req_i;
        forced = (m_phase == 2) && lr && (m_wait == MaxWait);
        eg_l = (m_phase == 0 && lr) || (m_phase == 2 && lr && (forced || !fr));
        eg_f = (m_phase == 2) && fr && !eg_l;
        e_we = eg_l && bus.l_we_i;
        e_addr = eg_l ? bus.l_addr_i : (eg_f ? bus.f_addr_i : '0);
        e_wdata = eg_l ? bus.l_wdata_i : '0;
        e_frv = p_valid && !p_ldr && bus.m_rvalid_i;
        e_lrv = p_valid && p_ldr && (p_we || bus.m_rvalid_i);

        chk("f_gnt", bus.f_gnt_o, eg_f);
        chk("l_gnt", bus.l_gnt_o, eg_l);
        chk("m_req", bus.m_req_o, eg_f || eg_l);
        chk("m_we", bus.m_we_o, e_we);
        chk("m_addr", bus.m_addr_o, e_addr);
        chk("m_wdata", bus.m_wdata_o, e_wdata);
        chk("m_wmask", bus.m_wmask_o, e_we ? {DW{1'b1}} : '0);
        chk("f_rvalid", bus.f_rvalid_o, e_frv);
        chk("f_rdata", bus.f_rdata_o, e_frv ? bus.m_rdata_i : '0);
        chk("l_rvalid", bus.l_rvalid_o, e_lrv);
        chk("l_rdata", bus.l_rdata_o, e_lrv ? bus.m_rdata_i : '0);
        chk("phase", phase, m_phase);
`ifdef ICCM_ARB_STATS_EN
        chk("conflict_cnt", conflict_cnt, m_conf);
        chk("starve_cnt", starve_cnt, m_starve);
`endif

        case (m_phase)
            0: n_phase = boot_hold ? 0 : 1;
            1: n_phase = boot_hold ? 0 : (p_valid ? 1 : 2);
            default: n_phase = boot_hold ? 0 : 2;
        endcase
        if (m_phase == 2 && !boot_hold && lr && !eg_l)
            n_wait = (m_wait < MaxWait) ? m_wait + 1 : MaxWait;
        else
            n_wait = 0;
        n_valid = eg_f || eg_l;
        n_ldr = eg_l;
        n_we = e_we;
        n_conf = m_conf + ((m_phase == 2 && fr && lr) ? 1 : 0);
        n_starve = m_starve + (forced ? 1 : 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        logic [19:0] pat;
        logic [StatW-1:0] s0;
        bus.f_req_i = 0; bus.f_addr_i = '0;
        bus.l_req_i = 0; bus.l_we_i = 0; bus.l_addr_i = '0; bus.l_wdata_i = '0;

        // Reset with boot hold.
        repeat (2) step();
        smp();
        chk("lit_reset_phase", phase, 2'd0);
        chk("lit_reset_m_req", bus.m_req_o, 1'b0);
        step();
        rst_ni = 1;

        // Loader write in LOAD while fetch asks too.
        step();
        bus.f_req_i = 1; bus.f_addr_i = 12'h010;
        bus.l_req_i = 1; bus.l_we_i = 1; bus.l_addr_i = 12'h010; bus.l_wdata_i = 32'hDEADBEEF;
        smp();
        chk("lit_load_l_gnt", bus.l_gnt_o, 1'b1);
        chk("lit_load_f_gnt", bus.f_gnt_o, 1'b0);
        chk("lit_load_wmask", bus.m_wmask_o, 32'hFFFFFFFF);
        chk("lit_load_wdata", bus.m_wdata_o, 32'hDEADBEEF);
        step();
        bus.l_req_i = 0; bus.l_we_i = 0;
        smp();
        chk("lit_write_ack", bus.l_rvalid_o, 1'b1);
        chk("lit_load_f_stall", bus.f_gnt_o, 1'b0);

        // Release boot hold: LOAD -> DRAIN -> RUN, then fetch reads back.
        step();
        boot_hold = 0;
        smp();
        chk("lit_phase_still_load", phase, 2'd0);
        step(); smp();
        chk("lit_phase_drain", phase, 2'd1);
        chk("lit_drain_f_gnt", bus.f_gnt_o, 1'b0);
        step(); smp();
        chk("lit_phase_run", phase, 2'd2);
        chk("lit_run_f_gnt", bus.f_gnt_o, 1'b1);
        step();
        bus.f_req_i = 0;
        smp();
        chk("lit_fetch_rvalid", bus.f_rvalid_o, 1'b1);
        chk("lit_fetch_rdata", bus.f_rdata_o, 32'hDEADBEEF);

        // Starvation bound: both requesting continuously.
        step();
`ifdef ICCM_ARB_STATS_EN
        s0 = starve_cnt;
`else
        s0 = '0;
`endif
        bus.f_req_i = 1; bus.l_req_i = 1; bus.l_we_i = 0;
        cnt = 0; pat = '0;
        for (int i = 0; i < 20; i++) begin
            bus.f_addr_i = 12'($urandom_range(0, 31));
            bus.l_addr_i = 12'($urandom_range(0, 31));
            smp();
            if (bus.l_gnt_o === 1'b1) begin
                cnt++;
                pat[i] = 1'b1;
            end
            step();
        end
        bus.f_req_i = 0; bus.l_req_i = 0;
        chk("lit_starve_count", cnt, 4);
        chk("lit_starve_pattern", pat, 20'h84210);
`ifdef ICCM_ARB_STATS_EN
        smp();
        chk("lit_starve_stat", starve_cnt - s0, 4);
`else
        chk("lit_starve_s0", s0, 0);
`endif

        // Fetch in N, loader read in N+1: returns must not cross.
        step();
        bus.f_req_i = 1; bus.f_addr_i = 12'h010;
        smp();
        chk("lit_seq_f_gnt", bus.f_gnt_o, 1'b1);
        step();
        bus.f_req_i = 0; bus.l_req_i = 1; bus.l_we_i = 0; bus.l_addr_i = 12'h010;
        smp();
        chk("lit_seq_f_rvalid", bus.f_rvalid_o, 1'b1);
        chk("lit_seq_l_rvalid_early", bus.l_rvalid_o, 1'b0);
        step();
        bus.l_req_i = 0;
        smp();
        chk("lit_seq_l_rvalid", bus.l_rvalid_o, 1'b1);
        chk("lit_seq_l_rdata", bus.l_rdata_o, 32'hDEADBEEF);
        chk("lit_seq_f_rvalid_late", bus.f_rvalid_o, 1'b0);

        // Boot hold raised with a read in flight.
        step();
        bus.f_req_i = 1; boot_hold = 1;
        smp();
        chk("lit_hold_f_gnt", bus.f_gnt_o, 1'b1);
        step();
        smp();
        chk("lit_hold_phase", phase, 2'd0);
        chk("lit_hold_rvalid", bus.f_rvalid_o, 1'b1);
        chk("lit_hold_no_gnt", bus.f_gnt_o, 1'b0);
        step();
        boot_hold = 0;
        repeat (3) step();

        // Reset in the cycle after a fetch grant.
        smp();
        chk("lit_rst_pre_gnt", bus.f_gnt_o, 1'b1);
        step();
        rst_ni = 0;
        smp();
        chk("lit_rst_f_rvalid", bus.f_rvalid_o, 1'b0);
        chk("lit_rst_phase", phase, 2'd0);
        chk("lit_rst_m_req", bus.m_req_o, 1'b0);
        step();
        rst_ni = 1; bus.f_req_i = 0;
        smp();
        chk("lit_rst_after", bus.f_rvalid_o, 1'b0);

        // Randomized traffic with occasional boot hold toggles and resets.
        for (int i = 0; i < 4000; i++) begin
            step();
            if (!rst_ni) rst_ni = 1;
            else if ($urandom_range(0, 599) == 0) rst_ni = 0;
            if ($urandom_range(0, 79) == 0) boot_hold = ~boot_hold;
            bus.f_req_i = ($urandom_range(0, 3) != 0);
            bus.f_addr_i = 12'($urandom_range(0, 63));
            bus.l_req_i = ($urandom_range(0, 2) != 0);
            bus.l_we_i = $urandom_range(0, 1);
            bus.l_addr_i = 12'($urandom_range(0, 63));
            bus.l_wdata_i = $urandom;
        end
        step();
        rst_ni = 1;
        bus.f_req_i = 0; bus.l_req_i = 0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iccm_port_arbiter.md
# iccm_port_arbiter

Shares the single-port instruction SRAM between two requesters: the core fetch path (read-only, behind the TL-UL SRAM adapter) and the program loader (UART/SPI-fed ICCM write path). A phase FSM gives the loader exclusive access while the core is held in boot reset, drains in-flight accesses, then runs the core with fetch priority and bounded loader starvation. The block sits between the adapter/loader and the `instr_mem_top` port and routes SRAM read data back to whichever requester owns it.

## Interface
- `AW`, 12: SRAM word address width
- `DW`, 32: data width
- `MaxWait`, 4: loader wait cycles in RUN before it is forced to win; must be ≥1
- `StatW`, 16: statistics counter width (used only with the stats macro)

- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `boot_hold_i` in 1: high while the core is held in reset for programming
- `f_req_i` in 1, `f_addr_i` in AW: fetch read request
- `f_gnt_o` out 1: fetch request accepted this cycle
- `f_rvalid_o` out 1, `f_rdata_o` out DW: fetch read return
- `l_req_i` in 1, `l_we_i` in 1, `l_addr_i` in AW, `l_wdata_i` in DW: loader request
- `l_gnt_o` out 1: loader request accepted this cycle
- `l_rvalid_o` out 1, `l_rdata_o` out DW: loader read return or write ack
- `m_req_o`, `m_we_o` out 1; `m_addr_o` out AW; `m_wdata_o`, `m_wmask_o` out DW: SRAM port
- `m_rdata_i` in DW, `m_rvalid_i` in 1: SRAM read return, fixed 1-cycle latency
- `phase_o` out 2: LOAD=0, DRAIN=1, RUN=2
- `conflict_cnt_o`, `starve_cnt_o` out StatW: present only with `ICCM_ARB_STATS_EN`

## Operation
- Phase FSM, reset state LOAD:
  - LOAD: only the loader is granted (`l_gnt_o = l_req_i`); `f_gnt_o = 0`. Goes to DRAIN when `boot_hold_i` = 0.
  - DRAIN: no grants. Goes to RUN when the owner register is empty (it holds at most one access). If `boot_hold_i` = 1, goes to LOAD.
  - RUN: fetch has priority. The loader is granted when fetch is idle, or when `wait_cnt == MaxWait`. Goes to LOAD when `boot_hold_i` = 1.
- `wait_cnt` (width clog2(MaxWait+1)):
  - Increments in RUN while `l_req_i` is high and `l_gnt_o` is low; saturates at MaxWait.
  - Clears on a loader grant, when `l_req_i` drops, or when leaving RUN.
- Grants are one-hot. `m_req_o` = `f_gnt_o | l_gnt_o`. The address, we and wdata of the winning requester are muxed to the SRAM port.
  - `m_we_o` is 1 only for a loader write. Fetch is always a read.
  - `m_wmask_o` is all-ones on a write and 0 otherwise. `m_wdata_o` is 0 on a fetch.
- Owner register {valid, who, we}: loaded on every grant, cleared otherwise.
  - A fetch read returns `f_rvalid_o` = `m_rvalid_i` & (who=fetch).
  - A loader read returns `l_rvalid_o` = `m_rvalid_i` & (who=loader).
  - A loader write returns `l_rvalid_o` = 1 one cycle after the grant, independent of `m_rvalid_i`.
- `f_rdata_o` and `l_rdata_o` equal `m_rdata_i` when their rvalid is high, 0 otherwise.

## Timing
- All outputs reset to 0 except `phase_o` = LOAD (0). `wait_cnt` and the owner register reset to 0.
- Grant is combinational, same cycle as the request. Read data returns exactly one cycle after the grant. The write ack also comes one cycle after the grant.
- Back-to-back grants every cycle are allowed; the owner register is overwritten each cycle.
- When both requesters ask in RUN with `wait_cnt < MaxWait`, fetch wins. With `wait_cnt == MaxWait`, the loader wins for exactly one access, then `wait_cnt` clears.
- A phase change takes effect the cycle after `boot_hold_i` changes. An access granted before the change still completes its return normally.
- An asynchronous reset mid-access drops the pending return: no rvalid is produced after reset release.
- A fetch request in LOAD or DRAIN stalls (no grant) and is never dropped.

## Configuration
- `ICCM_ARB_STATS_EN` defined:
  - `conflict_cnt_o` counts RUN cycles with both requests high.
  - `starve_cnt_o` counts forced loader grants (`wait_cnt == MaxWait`).
  - Both saturate at all-ones and reset to 0.
- Not defined: both ports and both counters are absent; all other behaviour is unchanged.

## Test plan
- Reset with `boot_hold_i` = 1; loader writes 0xDEADBEEF to addr 0x010 → `l_gnt_o` high the same cycle, SRAM write with full mask, `l_rvalid_o` pulse 1 cycle later; `f_req_i` held high gets no grant.
- Drop `boot_hold_i` → `phase_o` goes 0→1→2; fetch read of addr 0x010 → `f_gnt_o` the same cycle, `f_rvalid_o` with data 0xDEADBEEF one cycle later.
- RUN with `MaxWait` = 4, fetch and loader both requesting continuously → the loader is granted on exactly every 5th cycle; `starve_cnt_o` increments once per forced grant (stats build).
- Fetch granted in cycle N, loader granted in cycle N+1 → `f_rvalid_o` in N+1 only and `l_rvalid_o` in N+2 only; no cross-routing of data.
- Assert `rst_ni` low in the cycle after a fetch grant → no `f_rvalid_o` afterwards; all outputs 0 and `phase_o` = 0.
- Raise `boot_hold_i` in RUN with a read in flight → the read returns, `phase_o` = 0 next cycle, and fetch grants stop.
